rr_hold_arbiter: RTL and testbench

RR_HOLD_ARBITER -- requirements
Module: rr_hold_arbiter

---
 rtl/rr_hold_arbiter.sv | 152 +++++++++++++++
 tb/tb_rr_hold_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: four-agent round-robin arbiter with bounded grant hold.
//
// An owner keeps its grant while its request stays high. Once it has held for MAX_HOLD
// cycles and another agent is waiting, the grant is forcibly released and timeout pulses.
// Every release is followed by exactly one GAP cycle with all grants low. During that
// cycle the arbiter already picks the next owner, so the next grant rises one cycle later.
//
// Parameters
//   MAX_HOLD  maximum grant length while another agent waits (1..15)
//   HOLD_W    hold counter width; MAX_HOLD must be <= 2^HOLD_W-1
// Ports
//   clock          rising-edge clock
//   reset          synchronous active-high reset
//   req_0..req_3   level-held requests from agents 0..3
//   gnt_0..gnt_3   registered one-hot (or all-zero) grants
//   owner          index of the granted agent, valid while busy=1, held otherwise
//   busy           OR of the grants
//   timeout        one-cycle registered pulse marking a forced release
module rr_hold_arbiter #(
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned HOLD_W   = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_0,
  input  logic       req_1,
  input  logic       req_2,
  input  logic       req_3,
  output logic       gnt_0,
  output logic       gnt_1,
  output logic       gnt_2,
  output logic       gnt_3,
  output logic [1:0] owner,
  output logic       busy,
  output logic       timeout
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StGrant = 2'd1;
  localparam logic [1:0] StGap   = 2'd2;

  localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HoldOne = HOLD_W'(1);

  logic [1:0]        r_state;
  logic [3:0]        r_gnt;
  logic [1:0]        r_owner;
  logic [1:0]        r_last;
  logic [HOLD_W-1:0] r_hold;
  logic              r_timeout;

  logic [1:0]        w_state_d;
  logic [3:0]        w_gnt_d;
  logic [1:0]        w_owner_d;
  logic [1:0]        w_last_d;
  logic [HOLD_W-1:0] w_hold_d;
  logic              w_timeout_d;

  logic [3:0]        w_req;
  logic [1:0]        w_pick;
  logic              w_found;
  logic              w_owner_req;
  logic              w_others;
  logic              w_hold_max;

  assign w_req       = {req_3, req_2, req_1, req_0};
  assign w_owner_req = w_req[r_owner];
  assign w_others    = |(w_req & ~(4'b0001 << r_owner));
  assign w_hold_max  = (r_hold == HoldMax);

  // Search last+1 .. last+4 (mod 4); the previous owner is considered last.
  always_comb begin
    logic [1:0] w_idx;
    w_pick  = 2'd0;
    w_found = 1'b0;
    w_idx   = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_found && w_req[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_gnt_d     = r_gnt;
    w_owner_d   = r_owner;
    w_last_d    = r_last;
    w_hold_d    = r_hold;
    w_timeout_d = 1'b0;
    case (r_state)
      StIdle, StGap: begin
        if (w_found) begin
          w_state_d = StGrant;
          w_gnt_d   = 4'b0001 << w_pick;
          w_owner_d = w_pick;
          w_last_d  = w_pick;
          w_hold_d  = HoldOne;
        end else begin
          w_state_d = StIdle;
          w_gnt_d   = 4'b0000;
        end
      end
      StGrant: begin
        // Owner dropping wins over the forced-release condition: no timeout then.
        if (!w_owner_req) begin
          w_state_d = StGap;
          w_gnt_d   = 4'b0000;
        end else if (w_hold_max && w_others) begin
          w_state_d   = StGap;
          w_gnt_d     = 4'b0000;
          w_timeout_d = 1'b1;
        end else if (!w_hold_max) begin
          w_hold_d = r_hold + HoldOne;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_gnt_d   = 4'b0000;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= StIdle;
      r_gnt     <= 4'b0000;
      r_owner   <= 2'd0;
      r_last    <= 2'd3;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_gnt     <= w_gnt_d;
      r_owner   <= w_owner_d;
      r_last    <= w_last_d;
      r_hold    <= w_hold_d;
      r_timeout <= w_timeout_d;
    end
  end

  assign gnt_0   = r_gnt[0];
  assign gnt_1   = r_gnt[1];
  assign gnt_2   = r_gnt[2];
  assign gnt_3   = r_gnt[3];
  assign owner   = r_owner;
  assign busy    = |r_gnt;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// Directed bench for rr_hold_arbiter (MAX_HOLD=8). Inputs change and outputs are sampled
// 1 time unit after each rising clock edge.
module tb_rr_hold_arbiter;

  logic       clock;
  logic       reset;
  logic       req_0, req_1, req_2, req_3;
  logic       gnt_0, gnt_1, gnt_2, gnt_3;
  logic [1:0] owner;
  logic       busy;
  logic       timeout;

  int n_vec;
  int n_bad;

  rr_hold_arbiter #(
    .MAX_HOLD(8),
    .HOLD_W  (4)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .req_0  (req_0),
    .req_1  (req_1),
    .req_2  (req_2),
    .req_3  (req_3),
    .gnt_0  (gnt_0),
    .gnt_1  (gnt_1),
    .gnt_2  (gnt_2),
    .gnt_3  (gnt_3),
    .owner  (owner),
    .busy   (busy),
    .timeout(timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    {req_3, req_2, req_1, req_0} = r;
  endtask

  // Checks grants, busy and timeout against expectations.
  task automatic chk(input string tag, input logic [3:0] gnt_exp, input logic tmo_exp);
    logic [3:0] g;
    logic       b_exp;
    g     = {gnt_3, gnt_2, gnt_1, gnt_0};
    b_exp = (gnt_exp != 4'b0000);
    n_vec++;
    assert (g === gnt_exp) else begin
      n_bad++;
      $error("FAIL %s gnt: got %b want %b", tag, g, gnt_exp);
    end
    n_vec++;
    assert (busy === b_exp) else begin
      n_bad++;
      $error("FAIL %s busy: got %b want %b", tag, busy, b_exp);
    end
    n_vec++;
    assert (timeout === tmo_exp) else begin
      n_bad++;
      $error("FAIL %s timeout: got %b want %b", tag, timeout, tmo_exp);
    end
  endtask

  task automatic chk_owner(input string tag, input logic [1:0] own_exp);
    n_vec++;
    assert (owner === own_exp) else begin
      n_bad++;
      $error("FAIL %s owner: got %0d want %0d", tag, owner, own_exp);
    end
  endtask

  initial begin
    int a;
    n_vec = 0;
    n_bad = 0;
    reset = 1'b1;
    set_req(4'b0000);
    tick();
    tick();
    chk("reset", 4'b0000, 1'b0);
    chk_owner("reset", 2'd0);

    // All request while in reset: no grant at a reset edge.
    set_req(4'b1111);
    tick();
    chk("reset_req", 4'b0000, 1'b0);

    // Agent 0 first after reset, held 8 cycles, then forced release.
    reset = 1'b0;
    tick();
    chk("first_gnt0", 4'b0001, 1'b0);
    chk_owner("first_gnt0", 2'd0);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("hold0_c%0d", i), 4'b0001, 1'b0);
    end
    tick();
    chk("force0_gap", 4'b0000, 1'b1);

    // Rotation 1,2,3,0 each for 8 cycles with a timeout gap.
    for (int k = 0; k < 4; k++) begin
      a = (k + 1) % 4;
      tick();
      chk($sformatf("rot%0d_rise", a), 4'b0001 << a, 1'b0);
      chk_owner($sformatf("rot%0d_rise", a), 2'(a));
      for (int i = 2; i <= 8; i++) begin
        tick();
        chk($sformatf("rot%0d_c%0d", a, i), 4'b0001 << a, 1'b0);
      end
      tick();
      chk($sformatf("rot%0d_gap", a), 4'b0000, 1'b1);
    end

    // Gap with no requests goes idle.
    set_req(4'b0000);
    tick();
    chk("idle_after_rot", 4'b0000, 1'b0);

    // Lone agent 2 holds 20 cycles past MAX_HOLD without timeout.
    set_req(4'b0100);
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk($sformatf("solo2_c%0d", i), 4'b0100, 1'b0);
    end
    set_req(4'b0000);
    tick();
    chk("solo2_drop", 4'b0000, 1'b0);
    tick();
    chk("solo2_idle", 4'b0000, 1'b0);
    chk_owner("solo2_idle", 2'd2);

    // Three-cycle pulse on req_1.
    set_req(4'b0010);
    tick();
    chk("pulse1_c1", 4'b0010, 1'b0);
    tick();
    chk("pulse1_c2", 4'b0010, 1'b0);
    tick();
    chk("pulse1_c3", 4'b0010, 1'b0);
    set_req(4'b0000);
    tick();
    chk("pulse1_gap", 4'b0000, 1'b0);
    tick();
    chk("pulse1_idle", 4'b0000, 1'b0);
    chk_owner("pulse1_idle", 2'd1);

    // All request, last=1 so agent 2 wins; reset during its 4th cycle.
    set_req(4'b1111);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("pre_rst2_c%0d", i), 4'b0100, 1'b0);
    end
    reset = 1'b1;
    tick();
    chk("mid_reset", 4'b0000, 1'b0);
    chk_owner("mid_reset", 2'd0);
    reset = 1'b0;
    set_req(4'b1001);
    tick();
    chk("post_rst_gnt0", 4'b0001, 1'b0);
    chk_owner("post_rst_gnt0", 2'd0);

    // Owner 0 drops exactly when hold hits MAX with req_1 pending: voluntary.
    set_req(4'b0011);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk($sformatf("race0_c%0d", i), 4'b0001, 1'b0);
    end
    set_req(4'b0010);
    tick();
    chk("race_drop", 4'b0000, 1'b0);
    tick();
    chk("race_gnt1", 4'b0010, 1'b0);
    chk_owner("race_gnt1", 2'd1);

    // Agent 1 saturates alone, then a late req_0 forces release at once.
    for (int i = 2; i <= 12; i++) begin
      tick();
      chk($sformatf("sat1_c%0d", i), 4'b0010, 1'b0);
    end
    set_req(4'b0011);
    tick();
    chk("late_force", 4'b0000, 1'b1);
    tick();
    chk("late_gnt0", 4'b0001, 1'b0);
    chk_owner("late_gnt0", 2'd0);
    set_req(4'b0000);
    tick();
    chk("final_drop", 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
